ps2_scancode_sequencer: RTL and testbench

Drains the PS/2 keyboard receiver FIFO through its `ready`/`nextdata_n` handshake and assembles raw scan-code bytes (Set 2: `E0` extended prefix, `F0` break prefix) into single key events. It tracks modifier and Caps Lock state, flags or suppresses typematic repeats, and presents each event on a valid/ack interface. It sits between the keyboard receiver and the display/ASCII logic, and is the only block that pops the receiver FIFO.

---
 rtl/ps2_scancode_sequencer.sv | 147 ++++++++++++++
 tb/tb_ps2_scancode_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_sequencer.sv
// Pops the PS/2 receiver FIFO one byte at a time and folds Set 2 prefixes (E0, F0) into single
// key events with modifier, Caps Lock and typematic-repeat tracking on a valid/ack interface.
module ps2_scancode_sequencer #(
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       kbd_ready,
    input  logic [7:0] kbd_data,
    input  logic       kbd_overflow,
    output logic       kbd_nextdata_n,
    output logic       key_valid,
    input  logic       key_ack,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_repeat,
    output logic       shift,
    output logic       ctrl,
    output logic       caps_lock,
    output logic       overflow_seen
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_DECODE,
        S_EMIT
    } state_t;

    state_t     state_q;
    logic [7:0] byte_q;
    logic       ext_q, brk_q;
    logic [7:0] held_code_q;
    logic       held_ext_q, held_v_q;
    logic       lshift_q, rshift_q, lctrl_q, rctrl_q, caps_q;
    logic       nextdata_n_q, valid_q;
    logic [7:0] code_q;
    logic       ext_out_q, rel_q, rep_q, ovf_q;

    // Decode of the captured byte against the pending prefix flags.
    logic is_e0, is_f0, is_discard, held_match, is_rep;

    always_comb begin
        is_e0      = (byte_q == 8'hE0);
        is_f0      = (byte_q == 8'hF0);
        is_discard = 1'b0;
        case (byte_q)
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF, 8'hE1: is_discard = 1'b1;
            default:                                   is_discard = 1'b0;
        endcase
        held_match = held_v_q && (held_code_q == byte_q) && (held_ext_q == ext_q);
        is_rep     = !brk_q && held_match;
    end

    // NOTE: every register below uses <= so all state advances together on the edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= S_IDLE;
            byte_q       <= 8'h00;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            held_code_q  <= 8'h00;
            held_ext_q   <= 1'b0;
            held_v_q     <= 1'b0;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            lctrl_q      <= 1'b0;
            rctrl_q      <= 1'b0;
            caps_q       <= 1'b0;
            nextdata_n_q <= 1'b1;
            valid_q      <= 1'b0;
            code_q       <= 8'h00;
            ext_out_q    <= 1'b0;
            rel_q        <= 1'b0;
            rep_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            ovf_q <= ovf_q | kbd_overflow;
            case (state_q)
                S_IDLE: begin
                    if (kbd_ready) begin
                        byte_q       <= kbd_data;
                        nextdata_n_q <= 1'b0;
                        state_q      <= S_POP;
                    end
                end
                S_POP: begin
                    nextdata_n_q <= 1'b1;
                    state_q      <= S_DECODE;
                end
                S_DECODE: begin
                    state_q <= S_IDLE;
                    if (is_e0) begin
                        ext_q <= 1'b1;
                    end else if (is_f0) begin
                        brk_q <= 1'b1;
                    end else if (!is_discard) begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                        if (!brk_q) begin
                            held_code_q <= byte_q;
                            held_ext_q  <= ext_q;
                            held_v_q    <= 1'b1;
                        end else if (held_match) begin
                            held_v_q <= 1'b0;
                        end
                        // Modifiers track the key even when a repeat is suppressed.
                        if (byte_q == 8'h12)             lshift_q <= !brk_q;
                        if (byte_q == 8'h59 && !ext_q)   rshift_q <= !brk_q;
                        if (byte_q == 8'h14 && !ext_q)   lctrl_q  <= !brk_q;
                        if (byte_q == 8'h14 && ext_q)    rctrl_q  <= !brk_q;
                        if (byte_q == 8'h58 && !ext_q && !brk_q && !is_rep) caps_q <= !caps_q;
                        if (!(is_rep && SUPPRESS_REPEAT)) begin
                            code_q    <= byte_q;
                            ext_out_q <= ext_q;
                            rel_q     <= brk_q;
                            rep_q     <= is_rep;
                            valid_q   <= 1'b1;
                            state_q   <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    // Stay here without popping so unread bytes back up in the receiver.
                    if (key_ack) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign kbd_nextdata_n = nextdata_n_q;
    assign key_valid      = valid_q;
    assign key_code       = code_q;
    assign key_extended   = ext_out_q;
    assign key_release    = rel_q;
    assign key_repeat     = rep_q;
    assign shift          = lshift_q | rshift_q;
    assign ctrl           = lctrl_q | rctrl_q;
    assign caps_lock      = caps_q;
    assign overflow_seen  = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Directed bench: FIFO models feed two sequencers (repeat suppressed / emitted) with hand-built byte streams.
module tb_ps2_scancode_sequencer;

    logic       clk = 1'b0;
    logic       clrn;
    logic       kbd_overflow;
    logic       kbd_ready, kbd_ready1;
    logic [7:0] kbd_data, kbd_data1;
    logic       key_ack, key_ack1;
    logic       kbd_nextdata_n, key_valid, key_extended, key_release, key_repeat;
    logic       shift, ctrl, caps_lock, overflow_seen;
    logic [7:0] key_code;
    logic       kbd_nextdata_n1, key_valid1, key_extended1, key_release1, key_repeat1;
    logic       shift1, ctrl1, caps_lock1, overflow_seen1;
    logic [7:0] key_code1;

    always #5 clk = ~clk;

    ps2_scancode_sequencer #(.SUPPRESS_REPEAT(1'b1)) dut (
        .clk(clk), .clrn(clrn), .kbd_ready(kbd_ready), .kbd_data(kbd_data),
        .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n),
        .key_valid(key_valid), .key_ack(key_ack), .key_code(key_code),
        .key_extended(key_extended), .key_release(key_release), .key_repeat(key_repeat),
        .shift(shift), .ctrl(ctrl), .caps_lock(caps_lock), .overflow_seen(overflow_seen)
    );

    ps2_scancode_sequencer #(.SUPPRESS_REPEAT(1'b0)) dut_rep (
        .clk(clk), .clrn(clrn), .kbd_ready(kbd_ready1), .kbd_data(kbd_data1),
        .kbd_overflow(1'b0), .kbd_nextdata_n(kbd_nextdata_n1),
        .key_valid(key_valid1), .key_ack(key_ack1), .key_code(key_code1),
        .key_extended(key_extended1), .key_release(key_release1), .key_repeat(key_repeat1),
        .shift(shift1), .ctrl(ctrl1), .caps_lock(caps_lock1), .overflow_seen(overflow_seen1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Receiver FIFO models: pop on the edge closing a low strobe, present head on the falling edge.
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always @(posedge clk) begin
        if (kbd_nextdata_n === 1'b0 && q0.size() != 0) void'(q0.pop_front());
        if (kbd_nextdata_n1 === 1'b0 && q1.size() != 0) void'(q1.pop_front());
    end

    always @(negedge clk) begin
        kbd_ready  = (q0.size() != 0);
        kbd_data   = (q0.size() != 0) ? q0[0] : 8'h00;
        kbd_ready1 = (q1.size() != 0);
        kbd_data1  = (q1.size() != 0) ? q1[0] : 8'h00;
    end

    // Strobe and event monitors.
    logic prev_n  = 1'b1;
    logic prev_v  = 1'b0;
    logic prev_v1 = 1'b0;
    int   pops     = 0;
    int   last_pop = -10;
    int   evs      = 0;
    logic rep1_q[$];

    always @(negedge clk) begin
        if (kbd_nextdata_n === 1'b0) begin
            pops++;
            last_pop = cyc;
            check("pop single-cycle", 32'(prev_n), 32'(1));
        end
        prev_n = kbd_nextdata_n;
        if (key_valid === 1'b1 && prev_v !== 1'b1) evs++;
        prev_v = key_valid;
        if (key_valid1 === 1'b1 && prev_v1 !== 1'b1) rep1_q.push_back(key_repeat1);
        prev_v1 = key_valid1;
    end

    int latency;

    task automatic wait_valid(input string tag);
        int n = 0;
        while (key_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s valid", tag), 32'(key_valid), 32'(1));
        latency = cyc - last_pop;
    endtask

    task automatic expect_event(input string tag, input logic [7:0] code,
                                input logic ext, input logic rel, input logic rep);
        wait_valid(tag);
        check($sformatf("%s code", tag), 32'(key_code), 32'(code));
        check($sformatf("%s ext", tag), 32'(key_extended), 32'(ext));
        check($sformatf("%s rel", tag), 32'(key_release), 32'(rel));
        check($sformatf("%s rep", tag), 32'(key_repeat), 32'(rep));
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int         p0, e0;
    logic       stable;
    logic [3:0] rv;

    initial begin
        clrn = 1'b0;
        kbd_overflow = 1'b0;
        key_ack = 1'b0;
        key_ack1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst nextdata_n", 32'(kbd_nextdata_n), 32'(1));
        check("rst valid", 32'(key_valid), 32'(0));
        check("rst code", 32'(key_code), 32'(0));
        check("rst shift/ctrl/caps", 32'({shift, ctrl, caps_lock}), 32'(0));
        check("rst overflow", 32'(overflow_seen), 32'(0));
        clrn = 1'b1;
        @(negedge clk);

        // Simple make / break
        p0 = pops;
        q0.push_back(8'h1C); q0.push_back(8'hF0); q0.push_back(8'h1C);
        expect_event("mk1C", 8'h1C, 1'b0, 1'b0, 1'b0);
        check("pop-to-valid latency", 32'(latency), 32'(2));
        expect_event("br1C", 8'h1C, 1'b0, 1'b1, 1'b0);
        drain();
        check("make/break pops", 32'(pops - p0), 32'(3));

        // Extended key, prefixes produce no event of their own
        e0 = evs;
        q0.push_back(8'hE0); q0.push_back(8'h75);
        q0.push_back(8'hE0); q0.push_back(8'hF0); q0.push_back(8'h75);
        expect_event("mkE075", 8'h75, 1'b1, 1'b0, 1'b0);
        expect_event("brE075", 8'h75, 1'b1, 1'b1, 1'b0);
        drain();
        check("ext event count", 32'(evs - e0), 32'(2));

        // Typematic: suppressed on dut, flagged on dut_rep
        e0 = evs;
        foreach (q0[i]) ;
        q0.push_back(8'h1C); q0.push_back(8'h1C); q0.push_back(8'h1C);
        q0.push_back(8'hF0); q0.push_back(8'h1C);
        q1.push_back(8'h1C); q1.push_back(8'h1C); q1.push_back(8'h1C);
        q1.push_back(8'hF0); q1.push_back(8'h1C);
        expect_event("typ make", 8'h1C, 1'b0, 1'b0, 1'b0);
        expect_event("typ break", 8'h1C, 1'b0, 1'b1, 1'b0);
        drain();
        check("suppressed event count", 32'(evs - e0), 32'(2));
        check("emitted event count", 32'(rep1_q.size()), 32'(4));
        rv = 4'b0000;
        for (int i = 0; i < 4; i++) if (i < rep1_q.size()) rv[i] = rep1_q[i];
        check("emitted repeat flags", 32'(rv), 32'(4'b0110));

        // Modifiers
        q0.push_back(8'h12); q0.push_back(8'h58); q0.push_back(8'hF0); q0.push_back(8'h58);
        q0.push_back(8'h59); q0.push_back(8'hF0); q0.push_back(8'h12);
        expect_event("lshift mk", 8'h12, 1'b0, 1'b0, 1'b0);
        check("shift after lshift", 32'(shift), 32'(1));
        expect_event("caps mk", 8'h58, 1'b0, 1'b0, 1'b0);
        check("caps after make", 32'(caps_lock), 32'(1));
        expect_event("caps br", 8'h58, 1'b0, 1'b1, 1'b0);
        check("caps after break", 32'(caps_lock), 32'(1));
        expect_event("rshift mk", 8'h59, 1'b0, 1'b0, 1'b0);
        expect_event("lshift br", 8'h12, 1'b0, 1'b1, 1'b0);
        check("shift with rshift held", 32'(shift), 32'(1));
        check("ctrl before", 32'(ctrl), 32'(0));
        q0.push_back(8'hE0); q0.push_back(8'h14);
        expect_event("rctrl mk", 8'h14, 1'b1, 1'b0, 1'b0);
        check("ctrl after rctrl", 32'(ctrl), 32'(1));
        drain();

        // Back-pressure: hold ack with three bytes queued behind the event
        q0.push_back(8'h1A); q0.push_back(8'h1B); q0.push_back(8'h21); q0.push_back(8'h22);
        wait_valid("bp");
        check("bp code", 32'(key_code), 32'(8'h1A));
        p0 = pops;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (kbd_nextdata_n !== 1'b1 || key_valid !== 1'b1 || key_code !== 8'h1A ||
                key_extended !== 1'b0 || key_release !== 1'b0) stable = 1'b0;
        end
        check("bp outputs stable", 32'(stable), 32'(1));
        check("bp no pops", 32'(pops - p0), 32'(0));
        check("bp fifo depth", 32'(q0.size()), 32'(3));
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        expect_event("bp 1B", 8'h1B, 1'b0, 1'b0, 1'b0);
        expect_event("bp 21", 8'h21, 1'b0, 1'b0, 1'b0);
        expect_event("bp 22", 8'h22, 1'b0, 1'b0, 1'b0);
        drain();

        // Discarded bytes: no events, pending prefixes survive them
        e0 = evs;
        q0.push_back(8'hAA); q0.push_back(8'hFA); q0.push_back(8'h00); q0.push_back(8'hFF);
        drain();
        check("discard event count", 32'(evs - e0), 32'(0));
        q0.push_back(8'hE0); q0.push_back(8'hAA); q0.push_back(8'h75);
        expect_event("ext over discard", 8'h75, 1'b1, 1'b0, 1'b0);
        q0.push_back(8'hF0); q0.push_back(8'hFA); q0.push_back(8'h75);
        expect_event("brk over discard", 8'h75, 1'b0, 1'b1, 1'b0);
        drain();

        // Sticky overflow
        check("overflow before pulse", 32'(overflow_seen), 32'(0));
        kbd_overflow = 1'b1;
        @(negedge clk);
        kbd_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check("overflow sticky", 32'(overflow_seen), 32'(1));

        // Asynchronous reset during POP
        q0.push_back(8'h1C);
        begin
            int n = 0;
            while (kbd_nextdata_n !== 1'b0 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("reached POP", 32'(kbd_nextdata_n), 32'(0));
        #2 clrn = 1'b0;
        #1;
        check("async rst nextdata_n", 32'(kbd_nextdata_n), 32'(1));
        check("async rst valid", 32'(key_valid), 32'(0));
        check("async rst shift/ctrl/caps", 32'({shift, ctrl, caps_lock}), 32'(0));
        check("async rst overflow", 32'(overflow_seen), 32'(0));
        p0 = pops;
        q0.delete();
        repeat (5) @(negedge clk);
        clrn = 1'b1;
        repeat (5) @(negedge clk);
        check("no pop after reset", 32'(pops - p0), 32'(0));
        check("idle after reset", 32'(key_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
